// File: rtl/cpu_sequencer_if.sv
// Handshake/bus bundle between the datapath (master) and cpu_sequencer (slave).
interface cpu_sequencer_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        intr;
  logic        mem_ack;
  logic        pc_we;
  logic        ir_we;
  logic        rf_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        alu_src;
  logic        reg_dst;
  logic        mem2reg;
  logic [1:0]  pc_sel;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic        fault;
  logic [15:0] retired;

  modport master (
    output opcode, funct, zero, intr, mem_ack,
    input  pc_we, ir_we, rf_we, mem_rd, mem_wr, alu_src, reg_dst, mem2reg,
    input  pc_sel, alu_op, state, fault, retired
  );

  modport slave (
    input  opcode, funct, zero, intr, mem_ack,
    output pc_we, ir_we, rf_we, mem_rd, mem_wr, alu_src, reg_dst, mem2reg,
    output pc_sel, alu_op, state, fault, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a small MIPS subset (R-type, beq, j,
// addi, lw, sw). Optional interrupt support is enabled by defining
// SEQ_INT_EN; without it intr is ignored and INTR is never entered.
module cpu_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    BOOT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
    MEM  = 3'd4, WB    = 3'd5, INTR   = 3'd6, HALT = 3'd7
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam int         WW      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_e          state_q, state_d, fetch_ns;
  logic [5:0]      op_q, op_d, fn_q, fn_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            fault_q, fault_d;
  logic [15:0]     retired_q, retired_d;
  logic            pend_q, pend_clr, retire;
  logic [3:0]      rd_live, rd_q;   // {funct supported, alu_op}

  // R-type funct decode: {valid, alu_op}
  function automatic logic [3:0] r_dec(input logic [5:0] f);
    case (f)
      6'h24:   r_dec = 4'b1_000;
      6'h25:   r_dec = 4'b1_001;
      6'h20:   r_dec = 4'b1_010;
      6'h22:   r_dec = 4'b1_110;
      6'h2a:   r_dec = 4'b1_111;
      default: r_dec = 4'b0_000;
    endcase
  endfunction

  // State register and latched instruction fields / counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Next state, strobes and selects; every "go to FETCH" is diverted to INTR when an interrupt is pending
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fn_d        = fn_q;
    wait_d      = '0;
    fault_d     = fault_q;
    retired_d   = retired_q;
    pend_clr    = 1'b0;
    retire      = 1'b0;
    rd_live     = r_dec(bus.funct);
    rd_q        = r_dec(fn_q);
    fetch_ns    = pend_q ? INTR : FETCH;
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.rf_we   = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.alu_src = 1'b0;
    bus.reg_dst = 1'b0;
    bus.mem2reg = 1'b0;
    bus.pc_sel  = 2'b00;
    bus.alu_op  = 3'b000;
    case (state_q)
      BOOT: begin
        bus.pc_sel = 2'b11;
        bus.pc_we  = 1'b1;
        state_d    = fetch_ns;
      end
      FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        case (bus.opcode)
          OP_J: begin
            bus.pc_sel = 2'b10;
            bus.pc_we  = 1'b1;
            retire     = 1'b1;
            state_d    = fetch_ns;
          end
          OP_R:                           state_d = rd_live[3] ? EXEC : HALT;
          OP_BEQ, OP_ADDI, OP_LW, OP_SW:  state_d = EXEC;
          default:                        state_d = HALT;
        endcase
        if (state_d == HALT) fault_d = 1'b1;
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            bus.alu_op  = rd_q[2:0];
            bus.reg_dst = 1'b1;
            state_d     = WB;
          end
          OP_BEQ: begin
            bus.alu_op = 3'b110;
            bus.pc_sel = 2'b01;
            bus.pc_we  = bus.zero;
            retire     = 1'b1;
            state_d    = fetch_ns;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            bus.alu_op  = 3'b010;
            bus.alu_src = 1'b1;
            state_d     = (op_q == OP_ADDI) ? WB : MEM;
          end
          default: begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      MEM: begin
        bus.mem_rd = (op_q == OP_LW);
        bus.mem_wr = (op_q == OP_SW);
        // An ack wins even on the last allowed wait cycle
        if (bus.mem_ack) begin
          if (op_q == OP_LW) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = fetch_ns;
          end
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: begin
        bus.rf_we   = 1'b1;
        bus.mem2reg = (op_q == OP_LW);
        bus.reg_dst = (op_q == OP_R);
        retire      = 1'b1;
        state_d     = fetch_ns;
      end
      INTR: begin
        bus.pc_sel = 2'b11;
        bus.pc_we  = 1'b1;
        pend_clr   = 1'b1;
        state_d    = FETCH;
      end
      HALT: fault_d = 1'b1;
    endcase
    // The completing instruction still counts when its FETCH is diverted to INTR
    if (retire) retired_d = retired_q + 16'd1;
  end

`ifdef SEQ_INT_EN
  logic intr_q, pend_d;

  // Pending flag: set on intr rising edge (ignored in HALT), cleared by INTR; new edges merge
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | (bus.intr & ~intr_q & (state_q != HALT));
  end

  // Interrupt edge detector and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      intr_q <= bus.intr;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_intr;
  assign pend_q      = 1'b0;
  assign unused_intr = bus.intr ^ pend_clr;
`endif

  assign bus.state   = state_q;
  assign bus.fault   = fault_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks each instruction class through
// the FSM and checks strobes, latency, memory timeout, reset and wrap.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  cpu_sequencer_if sif();
  cpu_sequencer #(.WAIT_MAX(15)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

  always #5 clk = ~clk;

  // {pc_we, ir_we, rf_we, mem_rd, mem_wr, alu_src, reg_dst, mem2reg}
  function automatic logic [7:0] stb();
    return {sif.pc_we, sif.ir_we, sif.rf_we, sif.mem_rd,
            sif.mem_wr, sif.alu_src, sif.reg_dst, sif.mem2reg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] fn_tab [4];
    logic [2:0] op_tab [4];
    fn_tab = '{6'h24, 6'h25, 6'h22, 6'h2a};
    op_tab = '{3'b000, 3'b001, 3'b110, 3'b111};
    sif.opcode = 6'h00; sif.funct = 6'h00; sif.zero = 1'b0;
    sif.intr = 1'b0; sif.mem_ack = 1'b0;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", sif.state, 0);
    chk("rst_fault", sif.fault, 0);
    chk("rst_retired", sif.retired, 0);
    chk("rst_pcsel", sif.pc_sel, 2'b11);
    chk("rst_stb", stb(), 8'b1000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("boot_state", sif.state, 0);

    // R-type add
    sif.opcode = 6'h00; sif.funct = 6'h20;
    cyc(); chk("f_state", sif.state, 1); chk("f_stb", stb(), 8'b1100_0000); chk("f_pcsel", sif.pc_sel, 0);
    cyc(); chk("add_d_state", sif.state, 2);
    cyc(); chk("add_e_state", sif.state, 3); chk("add_aluop", sif.alu_op, 3'b010);
    chk("add_e_stb", stb(), 8'b0000_0010);
    cyc(); chk("add_wb_state", sif.state, 5); chk("add_wb_stb", stb(), 8'b0010_0010);
    cyc(); chk("add_ret_state", sif.state, 1); chk("add_retired", sif.retired, 1);

    // remaining R-type functs
    for (int i = 0; i < 4; i++) begin
      sif.funct = fn_tab[i];
      cyc(); cyc();
      chk("r_aluop", sif.alu_op, op_tab[i]);
      cyc(); cyc();
    end
    chk("r_retired", sif.retired, 5);

    // beq taken then not taken
    sif.opcode = 6'h04; sif.zero = 1'b1;
    cyc(); cyc();
    chk("beq1_state", sif.state, 3); chk("beq1_aluop", sif.alu_op, 3'b110);
    chk("beq1_pcsel", sif.pc_sel, 2'b01); chk("beq1_stb", stb(), 8'b1000_0000);
    cyc(); chk("beq1_fetch", sif.state, 1); chk("beq1_ret", sif.retired, 6);
    sif.zero = 1'b0;
    cyc(); cyc();
    chk("beq0_pcsel", sif.pc_sel, 2'b01); chk("beq0_stb", stb(), 8'b0000_0000);
    cyc(); chk("beq0_fetch", sif.state, 1); chk("beq0_ret", sif.retired, 7);

    // j
    sif.opcode = 6'h02;
    cyc(); chk("j_pcsel", sif.pc_sel, 2'b10); chk("j_stb", stb(), 8'b1000_0000);
    cyc(); chk("j_fetch", sif.state, 1); chk("j_ret", sif.retired, 8);

    // addi
    sif.opcode = 6'h08;
    cyc(); cyc(); chk("addi_aluop", sif.alu_op, 3'b010); chk("addi_e_stb", stb(), 8'b0000_0100);
    cyc(); chk("addi_wb_stb", stb(), 8'b0010_0000);
    cyc(); chk("addi_ret", sif.retired, 9);

    // lw, ack after 3 waits, intr pulse during MEM
    sif.opcode = 6'h23;
    cyc(); cyc(); chk("lw_e_stb", stb(), 8'b0000_0100);
    cyc(); chk("lw_m1_state", sif.state, 4); chk("lw_m1_stb", stb(), 8'b0001_0000);
    sif.intr = 1'b1;
    cyc(); sif.intr = 1'b0;
    cyc(); chk("lw_m3_rd", sif.mem_rd, 1);
    cyc(); sif.mem_ack = 1'b1; chk("lw_m4_state", sif.state, 4); chk("lw_m4_rd", sif.mem_rd, 1);
    cyc(); sif.mem_ack = 1'b0; chk("lw_wb_stb", stb(), 8'b0010_0001);
    cyc();
`ifdef SEQ_INT_EN
    chk("intr_state", sif.state, 6); chk("intr_pcsel", sif.pc_sel, 2'b11);
    chk("intr_stb", stb(), 8'b1000_0000);
    cyc();
`endif
    chk("lw_fetch", sif.state, 1); chk("lw_ret", sif.retired, 10);

    // sw with ack on the last allowed wait cycle
    sif.opcode = 6'h2b;
    cyc(); cyc(); cyc(); chk("sw_m1_stb", stb(), 8'b0000_1000);
    for (int i = 2; i <= 15; i++) cyc();
    sif.mem_ack = 1'b1; chk("sw_m15_state", sif.state, 4);
    cyc(); sif.mem_ack = 1'b0; chk("sw_ack_fetch", sif.state, 1); chk("sw_ret", sif.retired, 11);

    // sw timeout
    cyc(); cyc(); cyc();
    for (int i = 2; i <= 15; i++) cyc();
    chk("swto_m15_state", sif.state, 4); chk("swto_m15_wr", sif.mem_wr, 1);
    cyc(); chk("swto_state", sif.state, 7); chk("swto_fault", sif.fault, 1);
    chk("swto_stb", stb(), 8'b0000_0000); chk("swto_pcsel", sif.pc_sel, 0);
    sif.intr = 1'b1; cyc(); sif.intr = 1'b0; cyc(); cyc();
    chk("halt_state", sif.state, 7); chk("halt_fault", sif.fault, 1);
    chk("halt_stb", stb(), 8'b0000_0000); chk("halt_ret", sif.retired, 11);

    // reset out of HALT
    rst_n = 1'b0; #1;
    chk("rst2_state", sif.state, 0); chk("rst2_fault", sif.fault, 0);
    chk("rst2_ret", sif.retired, 0); chk("rst2_stb", stb(), 8'b1000_0000);
    @(negedge clk); rst_n = 1'b1;

    // unsupported opcode
    sif.opcode = 6'h3f;
    cyc(); cyc(); cyc(); chk("bad_op_state", sif.state, 7); chk("bad_op_fault", sif.fault, 1);
    do_reset();

    // unsupported R-type funct
    sif.opcode = 6'h00; sif.funct = 6'h3f;
    cyc(); cyc(); cyc(); chk("bad_fn_state", sif.state, 7); chk("bad_fn_fault", sif.fault, 1);
    do_reset();

    // reset mid-MEM drops mem_rd immediately
    sif.opcode = 6'h23;
    cyc(); cyc(); cyc(); cyc(); chk("mid_rd", sif.mem_rd, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_rd", sif.mem_rd, 0); chk("mid_rst_state", sif.state, 0);
    @(negedge clk); rst_n = 1'b1;

    // retired wrap: preload near the top instead of running 0xFFFF instructions
    sif.opcode = 6'h02;
    cyc();
    force dut.retired_q = 16'hfffe;
    cyc();
    release dut.retired_q;
    chk("wrap_pre", sif.retired, 16'hfffe);
    cyc(); chk("wrap_ffff", sif.retired, 16'hffff);
    cyc(); cyc(); chk("wrap_0000", sif.retired, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
